gemv_requant: RTL and testbench
===============================

Name: gemv_requant

Overview:
- Downstream stage of gemv_core: drains its int32 Y results through the core's y_rd_en/y_rd_data read port.
- Each result is requantized to int8 (fixed-point scale, round, zero-point, optional ReLU, saturate).
- Each int8 is pushed through an x_wr_en/x_wr_data write port that connects directly to the next layer's gemv_core X input, so layers chain without CPU copies.

Parameters:
- ACC_W, 32, width of the accumulator read from gemv_core (fixed; no other value supported).
- CNT_W, 7, width of the element index and saturation counters (holds 0..64).

Ports:
- clk  input  1  clock; all flops rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begin draining (accepted only in IDLE).
- count_64  input  1  element count: 0 -> 32, 1 -> 64. Latched on start.
- mult  input  32  signed scale multiplier. Latched on start.
- shift  input  5  right shift 0..31. Latched on start.
- zero_point  input  8  signed int8 output zero point. Latched on start.
- relu_en  input  1  clamp output low bound to zero_point. Latched on start.
- clear_done  input  1  pulse; DONE -> IDLE.
- busy  output  1  high in RD/MUL/QNT/WR.
- done  output  1  high in DONE.
- sat_count  output  7  number of saturated elements in the last run.
- y_rd_en  output  1  advance pulse to gemv_core read index.
- y_rd_data  input  32  gemv_core current Y element (combinational from the core).
- x_wr_en  output  1  write pulse to next-layer X buffer.
- x_wr_data  output  8  int8 value accompanying x_wr_en.

Behaviour:
- Reset (asynchronous, any state including mid-run):
  - state=IDLE, idx=0, sat_count=0.
  - busy=0, done=0, y_rd_en=0, x_wr_en=0, x_wr_data=0.
  - Internal pipeline registers cleared.
- FSM states: IDLE, RD, MUL, QNT, WR, DONE. All outputs are registered/state-decoded, with no combinational path from inputs to outputs.
- IDLE:
  - start=1 latches the config, clears idx and sat_count, and moves to RD.
  - start in any other state is ignored.
- RD (1 cycle): y_rd_en=1. y_raw <= y_rd_data at the exiting edge, i.e. the same edge on which gemv_core advances its index.
- MUL (1 cycle): prod <= $signed(y_raw) * $signed(mult), 64-bit signed.
- QNT (1 cycle):
  - If shift>0: r = (prod + (1<<(shift-1))) >>> shift; if shift=0: r = prod. This is round-half-toward-+inf, arithmetic shift.
  - v = r + sext(zero_point), 64-bit.
  - lo = relu_en ? zero_point : -128; hi = 127.
  - x_wr_data <= clamp(v, lo, hi).
  - sat_count increments if v>127 or v<-128. A ReLU-only clamp does NOT count.
- WR (1 cycle): x_wr_en=1 and x_wr_data stable. If idx == N-1 go to DONE, else idx++ and go to RD.
- Cadence: exactly 4 cycles per element.
  - First y_rd_en occurs the cycle after start.
  - done rises 4N+1 cycles after the start edge: 129 for N=32, 257 for N=64.
  - Exactly N y_rd_en pulses and N x_wr_en pulses per run, never overlapping in the same cycle.
- DONE: done held until clear_done. clear_done -> IDLE with done=0 the next cycle. sat_count is retained until the next start.
- clear_done outside DONE is ignored. Runs are not abortable except by reset.
- Precondition (system controller's responsibility): gemv_core read index and next-layer X write index are at 0 before start. This block never resets them.
- Config inputs may change freely after start without effect.
- No overflow: |y*mult| < 2^63.

Test Plan:
- mult=1, shift=0, zp=0, relu=0, N=32; Y[0..3] = 100, 200, -300, -128, rest 0 -> X = 100, 127, -128, -128, then 0s; sat_count=2; done at start+129 cycles.
- Rounding with mult=1, shift=2; Y = 6, -6, 5, -5, 2, -2 -> X = 2, -1, 1, -1, 1, 0.
- Scale with mult=0x40000000, shift=31 (×0.5), zp=3; Y = 41, -41, 1000 -> X = 24, -17, 127 (saturated, counted); sat_count=1.
- ReLU with relu_en=1, zp=-10, mult=1, shift=0; Y = -50, 5, 200 -> X = -10, -5, 127; sat_count=1 (ReLU clamp on -50 not counted).
- N=64 chained into a real gemv_core pair (layer-1 output feeds layer-2 X) -> 64 y_rd_en and 64 x_wr_en pulses, one per 4 cycles; layer-2 result matches the golden model.
- Control edge cases:
  - start pulsed again mid-run -> ignored, pulse count unchanged.
  - clear_done mid-run -> ignored.
  - reset asserted at element 10 -> all outputs 0 immediately (asynchronously); IDLE after release; a fresh run is correct.

Source files
------------

// File: rtl/gemv_requant_if.sv
// Read/write port bundle between a gemv_requant stage and its neighbouring gemv_cores:
// the Y read port of the upstream core and the X write port of the downstream core.
interface gemv_requant_if;
   logic        y_rd_en;
   logic [31:0] y_rd_data;
   logic        x_wr_en;
   logic [7:0]  x_wr_data;

   // requantizer side
   modport master (
      output y_rd_en,
      input  y_rd_data,
      output x_wr_en,
      output x_wr_data
   );

   // core / buffer side
   modport slave (
      input  y_rd_en,
      output y_rd_data,
      input  x_wr_en,
      input  x_wr_data
   );
endinterface

// File: rtl/gemv_requant.sv
// gemv_requant: drains int32 accumulator results from a gemv_core, requantizes each
// to int8 (scale, round half toward +inf, zero point, optional ReLU, saturate) and
// writes it straight into the next layer's X buffer. Four cycles per element:
// RD -> MUL -> QNT -> WR, all outputs registered.
module gemv_requant #(
   parameter int ACC_W = 32,
   parameter int CNT_W = 7
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               count_64,
   input  logic [31:0]        mult,
   input  logic [4:0]         shift,
   input  logic [7:0]         zero_point,
   input  logic               relu_en,
   input  logic               clear_done,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   sat_count,
   gemv_requant_if.master     bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_MUL,
      S_QNT,
      S_WR,
      S_DONE
   } state_t;

   // Rounding right shift: adds half an LSB of the result before the arithmetic shift,
   // so ties go toward +inf. A zero shift passes the product through untouched.
   function automatic logic signed [63:0] round_shift(input logic signed [63:0] p,
                                                      input logic [4:0] sh);
      logic signed [63:0] bias;
      bias = 64'sd1 <<< (sh - 5'd1);
      if (sh == 5'd0) begin
         return p;
      end
      return (p + bias) >>> sh;
   endfunction

   // Clamp to [lo, 127]; lo is either -128 or the zero point when ReLU is on.
   function automatic logic [7:0] clamp_int8(input logic signed [63:0] v,
                                             input logic signed [63:0] lo);
      if (v > 64'sd127) begin
         return 8'h7f;
      end else if (v < lo) begin
         return lo[7:0];
      end
      return v[7:0];
   endfunction

   // Only a true int8 overflow counts; the ReLU floor is not a saturation event.
   function automatic logic is_sat(input logic signed [63:0] v);
      return (v > 64'sd127) || (v < -64'sd128);
   endfunction

   state_t                   state_q, state_d;
   logic [CNT_W-1:0]         idx_q, idx_d;
   logic [CNT_W-1:0]         sat_q, sat_d;
   logic                     cnt64_q, cnt64_d;
   logic signed [31:0]       mult_q, mult_d;
   logic [4:0]               shift_q, shift_d;
   logic signed [7:0]        zp_q, zp_d;
   logic                     relu_q, relu_d;
   logic signed [ACC_W-1:0]  y_raw_q, y_raw_d;
   logic signed [2*ACC_W-1:0] prod_q, prod_d;
   logic [7:0]               x_data_q, x_data_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     y_rd_en_q, y_rd_en_d;
   logic                     x_wr_en_q, x_wr_en_d;

   logic signed [63:0]       zp_ext;
   logic signed [63:0]       qnt_v;
   logic signed [63:0]       qnt_lo;
   logic [CNT_W-1:0]         last_idx;

   assign zp_ext   = $signed({{56{zp_q[7]}}, zp_q});
   assign qnt_v    = round_shift(prod_q, shift_q) + zp_ext;
   assign qnt_lo   = relu_q ? zp_ext : -64'sd128;
   assign last_idx = cnt64_q ? CNT_W'(63) : CNT_W'(31);

   // Next-state and datapath: one stage of work per state, outputs decoded from next state
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      sat_d    = sat_q;
      cnt64_d  = cnt64_q;
      mult_d   = mult_q;
      shift_d  = shift_q;
      zp_d     = zp_q;
      relu_d   = relu_q;
      y_raw_d  = y_raw_q;
      prod_d   = prod_q;
      x_data_d = x_data_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt64_d = count_64;
               mult_d  = $signed(mult);
               shift_d = shift;
               zp_d    = $signed(zero_point);
               relu_d  = relu_en;
               idx_d   = '0;
               sat_d   = '0;
               state_d = S_RD;
            end
         end
         S_RD: begin
            // captured on the same edge the core advances its read index
            y_raw_d = $signed(bus.y_rd_data);
            state_d = S_MUL;
         end
         S_MUL: begin
            prod_d  = y_raw_q * mult_q;
            state_d = S_QNT;
         end
         S_QNT: begin
            x_data_d = clamp_int8(qnt_v, qnt_lo);
            if (is_sat(qnt_v)) begin
               sat_d = sat_q + CNT_W'(1);
            end
            state_d = S_WR;
         end
         S_WR: begin
            if (idx_q == last_idx) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + CNT_W'(1);
               state_d = S_RD;
            end
         end
         S_DONE: begin
            if (clear_done) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d    = (state_d == S_RD) || (state_d == S_MUL) ||
                  (state_d == S_QNT) || (state_d == S_WR);
      done_d    = (state_d == S_DONE);
      y_rd_en_d = (state_d == S_RD);
      x_wr_en_d = (state_d == S_WR);
   end

   // State, config, pipeline and output registers; reset clears everything
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         sat_q     <= '0;
         cnt64_q   <= 1'b0;
         mult_q    <= '0;
         shift_q   <= '0;
         zp_q      <= '0;
         relu_q    <= 1'b0;
         y_raw_q   <= '0;
         prod_q    <= '0;
         x_data_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         y_rd_en_q <= 1'b0;
         x_wr_en_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         sat_q     <= sat_d;
         cnt64_q   <= cnt64_d;
         mult_q    <= mult_d;
         shift_q   <= shift_d;
         zp_q      <= zp_d;
         relu_q    <= relu_d;
         y_raw_q   <= y_raw_d;
         prod_q    <= prod_d;
         x_data_q  <= x_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         y_rd_en_q <= y_rd_en_d;
         x_wr_en_q <= x_wr_en_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign sat_count     = sat_q;
   assign bus.y_rd_en   = y_rd_en_q;
   assign bus.x_wr_en   = x_wr_en_q;
   assign bus.x_wr_data = x_data_q;

endmodule

// File: tb/tb_gemv_requant.sv
// Scoreboard bench for gemv_requant: a behavioural Y source and X sink stand in for
// the neighbouring gemv_cores; expected int8 values are queued before each run and
// popped as x_wr_en pulses appear.
module tb_gemv_requant;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        count_64;
   logic [31:0] mult;
   logic [4:0]  shift;
   logic [7:0]  zero_point;
   logic        relu_en;
   logic        clear_done;
   logic        busy;
   logic        done;
   logic [6:0]  sat_count;

   gemv_requant_if bus_if ();

   gemv_requant dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .count_64   (count_64),
      .mult       (mult),
      .shift      (shift),
      .zero_point (zero_point),
      .relu_en    (relu_en),
      .clear_done (clear_done),
      .busy       (busy),
      .done       (done),
      .sat_count  (sat_count),
      .bus        (bus_if)
   );

   always #5 clk = ~clk;

   int     n_tests = 0;
   int     n_fail  = 0;
   int     cyc     = 0;
   longint exp_q[$];

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Y source (upstream core) and X sink (downstream core)
   logic [31:0]       ymem [64];
   logic signed [7:0] xmem [64];
   longint            gold [64];
   logic [6:0]        rd_idx;
   logic [6:0]        wr_idx;
   logic              src_clr;

   assign bus_if.y_rd_data = ymem[rd_idx[5:0]];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (src_clr) begin
         rd_idx <= '0;
         wr_idx <= '0;
      end else begin
         if (bus_if.y_rd_en) rd_idx <= rd_idx + 7'd1;
         if (bus_if.x_wr_en) begin
            xmem[wr_idx[5:0]] <= $signed(bus_if.x_wr_data);
            wr_idx <= wr_idx + 7'd1;
         end
      end
   end

   // Output monitor: pulse counting, exclusivity, cadence and scoreboard pops
   int y_cnt = 0;
   int x_cnt = 0;
   int last_x_cyc = 0;
   bit prev_x_ok = 1'b0;

   always @(negedge clk) begin
      if (reset || !busy) begin
         prev_x_ok <= 1'b0;
      end
      if (!reset) begin
         if (busy) chk("rd_wr_overlap", longint'(bus_if.y_rd_en & bus_if.x_wr_en), 0);
         if (bus_if.y_rd_en) y_cnt <= y_cnt + 1;
         if (bus_if.x_wr_en) begin
            x_cnt <= x_cnt + 1;
            if (prev_x_ok) chk("x_spacing", longint'(cyc - last_x_cyc), 4);
            last_x_cyc <= cyc;
            prev_x_ok  <= 1'b1;
            if (exp_q.size() == 0) chk("x_unexpected", 1, 0);
            else chk("x_data", longint'($signed(bus_if.x_wr_data)), exp_q.pop_front());
         end
      end
   end

   // Reference requantizer using floor division rather than shifts
   function automatic longint ref_q(input longint y, input longint m, input int sh,
                                    input longint zp, input bit re, output bit sat);
      longint p, d, q, lo;
      p = y * m;
      if (sh == 0) begin
         q = p;
      end else begin
         d = longint'(1) << sh;
         p = p + d / 2;
         q = p / d;
         if ((p % d) != 0 && p < 0) q = q - 1;
      end
      q   = q + zp;
      sat = (q > 127) || (q < -128);
      lo  = re ? zp : -128;
      if (q > 127) return 127;
      if (q < lo) return lo;
      return q;
   endfunction

   task automatic clear_y();
      for (int i = 0; i < 64; i++) ymem[i] = '0;
   endtask

   task automatic push_n(input longint v, input int cnt);
      for (int i = 0; i < cnt; i++) exp_q.push_back(v);
   endtask

   // One full run: start, optional mid-run start/clear_done pokes, latency and count checks
   task automatic run(input int n, input logic c64, input logic [31:0] m, input logic [4:0] sh,
                      input logic [7:0] zp, input logic re, input int exp_sat, input bit poke);
      int lat;
      int y0;
      int x0;
      @(negedge clk);
      src_clr = 1'b1;
      @(negedge clk);
      src_clr = 1'b0;
      y0 = y_cnt;
      x0 = x_cnt;
      count_64 = c64; mult = m; shift = sh; zero_point = zp; relu_en = re;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      chk("first_rd", longint'(bus_if.y_rd_en), 1);
      chk("busy_run", longint'(busy), 1);
      mult = $urandom; shift = 5'($urandom); zero_point = 8'($urandom);
      relu_en = ~re; count_64 = ~c64;
      while (!done && lat < 4 * n + 40) begin
         if (poke && lat == 40) start = 1'b1;
         if (poke && lat == 41) begin
            start = 1'b0;
            clear_done = 1'b1;
         end
         if (poke && lat == 42) clear_done = 1'b0;
         @(negedge clk);
         lat++;
         if (poke && lat == 43) chk("busy_after_poke", longint'(busy), 1);
      end
      chk("done_latency", longint'(lat), longint'(4 * n + 1));
      #1;
      chk("y_pulses", longint'(y_cnt - y0), longint'(n));
      chk("x_pulses", longint'(x_cnt - x0), longint'(n));
      chk("sat_count", longint'(sat_count), longint'(exp_sat));
      chk("busy_done", longint'(busy), 0);
      chk("queue_left", longint'(exp_q.size()), 0);
      @(negedge clk);
      chk("done_hold", longint'(done), 1);
      clear_done = 1'b1;
      @(negedge clk);
      clear_done = 1'b0;
      chk("done_clear", longint'(done), 0);
      chk("sat_retain", longint'(sat_count), longint'(exp_sat));
   endtask

   // Random data run checked against the reference model
   task automatic rand_run(input int n, input logic c64, input logic [31:0] m, input logic [4:0] sh,
                           input logic [7:0] zp, input logic re, input bit poke);
      int nsat;
      bit s;
      nsat = 0;
      for (int i = 0; i < 64; i++) ymem[i] = 32'(int'($urandom_range(0, 8000)) - 4000);
      for (int i = 0; i < n; i++) begin
         gold[i] = ref_q(longint'($signed(ymem[i])), longint'($signed(m)), int'(sh),
                         longint'($signed(zp)), re, s);
         if (s) nsat++;
         exp_q.push_back(gold[i]);
      end
      run(n, c64, m, sh, zp, re, nsat, poke);
   endtask

   longint dot_dut;
   longint dot_gold;
   int     wl;
   int     x0r;

   initial begin
      reset = 1'b1; src_clr = 1'b1; start = 1'b0; count_64 = 1'b0; mult = '0;
      shift = '0; zero_point = '0; relu_en = 1'b0; clear_done = 1'b0;
      clear_y();
      repeat (3) @(negedge clk);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_y_rd_en", longint'(bus_if.y_rd_en), 0);
      chk("rst_x_wr_en", longint'(bus_if.x_wr_en), 0);
      chk("rst_x_wr_data", longint'(bus_if.x_wr_data), 0);
      chk("rst_sat", longint'(sat_count), 0);
      reset = 1'b0;
      src_clr = 1'b0;
      @(negedge clk);

      // clear_done while idle must not disturb anything
      clear_done = 1'b1;
      @(negedge clk);
      clear_done = 1'b0;
      chk("idle_clear", longint'(busy | done), 0);

      // Basic saturation, N=32
      clear_y();
      ymem[0] = 32'd100; ymem[1] = 32'd200; ymem[2] = -32'sd300; ymem[3] = -32'sd128;
      exp_q.push_back(100); exp_q.push_back(127); exp_q.push_back(-128); exp_q.push_back(-128);
      push_n(0, 28);
      run(32, 1'b0, 32'd1, 5'd0, 8'd0, 1'b0, 2, 1'b0);

      // Rounding half toward +inf
      clear_y();
      ymem[0] = 32'd6; ymem[1] = -32'sd6; ymem[2] = 32'd5; ymem[3] = -32'sd5;
      ymem[4] = 32'd2; ymem[5] = -32'sd2;
      exp_q.push_back(2); exp_q.push_back(-1); exp_q.push_back(1);
      exp_q.push_back(-1); exp_q.push_back(1); exp_q.push_back(0);
      push_n(0, 26);
      run(32, 1'b0, 32'd1, 5'd2, 8'd0, 1'b0, 0, 1'b0);

      // Fixed-point x0.5 scale with zero point 3
      clear_y();
      ymem[0] = 32'd41; ymem[1] = -32'sd41; ymem[2] = 32'd1000;
      exp_q.push_back(24); exp_q.push_back(-17); exp_q.push_back(127);
      push_n(3, 29);
      run(32, 1'b0, 32'h4000_0000, 5'd31, 8'd3, 1'b0, 1, 1'b0);

      // ReLU floor at zero point -10 (not counted as saturation)
      clear_y();
      ymem[0] = -32'sd50; ymem[1] = 32'd5; ymem[2] = 32'd200;
      exp_q.push_back(-10); exp_q.push_back(-5); exp_q.push_back(127);
      push_n(-10, 29);
      run(32, 1'b0, 32'd1, 5'd0, 8'hf6, 1'b1, 1, 1'b0);

      // N=64 random, then layer-2 dot product over the written X buffer
      rand_run(64, 1'b1, 32'd3000, 5'd14, 8'd5, 1'b0, 1'b0);
      dot_dut = 0;
      dot_gold = 0;
      for (int i = 0; i < 64; i++) begin
         wl = (i % 7) - 3;
         dot_dut  += longint'(xmem[i]) * wl;
         dot_gold += gold[i] * wl;
      end
      chk("layer2_dot", dot_dut, dot_gold);

      // Mid-run start and clear_done are ignored
      rand_run(32, 1'b0, -32'sd2500, 5'd12, 8'hfd, 1'b1, 1'b1);

      // Asynchronous reset at element 10, then a fresh run
      rand_run_prep: begin
         bit s;
         for (int i = 0; i < 64; i++) ymem[i] = 32'(int'($urandom_range(0, 8000)) - 4000);
         for (int i = 0; i < 64; i++)
            exp_q.push_back(ref_q(longint'($signed(ymem[i])), 4000, 13, 0, 1'b0, s));
      end
      @(negedge clk);
      src_clr = 1'b1;
      @(negedge clk);
      src_clr = 1'b0;
      x0r = x_cnt;
      count_64 = 1'b1; mult = 32'd4000; shift = 5'd13; zero_point = 8'd0; relu_en = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wl = 0;
      while ((x_cnt - x0r) < 10 && wl < 200) begin
         @(negedge clk);
         wl++;
      end
      chk("elem10_reached", longint'(wl < 200), 1);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_busy", longint'(busy), 0);
      chk("arst_done", longint'(done), 0);
      chk("arst_y_rd_en", longint'(bus_if.y_rd_en), 0);
      chk("arst_x_wr_en", longint'(bus_if.x_wr_en), 0);
      chk("arst_x_wr_data", longint'(bus_if.x_wr_data), 0);
      chk("arst_sat", longint'(sat_count), 0);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_rst_idle", longint'(busy | done | bus_if.y_rd_en), 0);
      rand_run(32, 1'b0, 32'd7000, 5'd16, 8'h10, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global guard so the bench always ends
   initial begin
      #2000000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
